tl_rx_vc_hdr_fetch: RTL

TL_RX_VC_HDR_FETCH -- requirements
Module: tl_rx_vc_hdr_fetch

---
 rtl/tl_rx_vc_hdr_fetch_pkg.sv | 15 +
 rtl/tl_rx_vc_hdr_fetch_cr_calc.sv | 25 ++
 rtl/tl_rx_vc_hdr_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/tl_rx_vc_hdr_fetch_pkg.sv
// TL RX virtual-channel header fetch: shared types and DW0 field layout.
// Imported by the fetch stage and its credit calculator.
package tl_rx_vc_hdr_fetch_pkg;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } fetch_state_e;

  localparam int FMT_HAS_DATA_BIT = 30;
  localparam int LENGTH_MSB       = 9;
  localparam int LENGTH_W         = LENGTH_MSB + 1;
  localparam int CR_W             = 9;

endpackage

// File: rtl/tl_rx_vc_hdr_fetch_cr_calc.sv
// Data credit count for one TLP header.
// One credit per 4 DW, rounded up; length 0 encodes 1024 DW.
module tl_rx_vc_cr_calc
  import tl_rx_vc_hdr_fetch_pkg::*;
(
  input  logic [LENGTH_W-1:0] i_length,
  input  logic                i_has_data,
  output logic [CR_W-1:0]     o_credits
);

  logic [LENGTH_W:0] len_dw;
  logic [LENGTH_W:0] len_rnd;

  // expand the length field, round up to whole credits
  always_comb begin
    len_dw    = {1'b0, i_length};
    if (i_length == '0)
      len_dw  = {1'b1, {LENGTH_W{1'b0}}};
    len_rnd   = len_dw + (LENGTH_W+1)'(3);
    o_credits = '0;
    if (i_has_data)
      o_credits = len_rnd[LENGTH_W:2];
  end

endmodule

// File: rtl/tl_rx_vc_hdr_fetch.sv
// TL RX header fetch stage: pulls headers from the VC header buffer
// into an output register and releases header/data credits.
module tl_rx_vc_hdr_fetch
  import tl_rx_vc_hdr_fetch_pkg::*;
#(
  parameter int DW             = 32,
  parameter int HDR_FIELD_SIZE = 8,
  parameter int BUFFER_WIDTH   = 4*DW
)(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [HDR_FIELD_SIZE-1:0] i_w_hdr_ptr,
  input  logic [HDR_FIELD_SIZE-1:0] i_r_hdr_ptr,
  input  logic [BUFFER_WIDTH-1:0]   i_r_tlp_hdr,
  output logic                      o_r_hdr_inc,
  output logic                      o_hdr_valid,
  input  logic                      i_hdr_ready,
  output logic [BUFFER_WIDTH-1:0]   o_hdr,
  output logic                      o_hdr_has_data,
  output logic [LENGTH_W-1:0]       o_hdr_length,
  output logic                      o_cr_hdr_rel,
  output logic [CR_W-1:0]           o_cr_data_rel,
  output logic [HDR_FIELD_SIZE-1:0] o_hdr_count,
  output logic                      o_ptr_err
);

  localparam logic [HDR_FIELD_SIZE-1:0] DEPTH =
    {1'b1, {(HDR_FIELD_SIZE-1){1'b0}}};
  localparam int DW0_LSB = BUFFER_WIDTH - DW;

  fetch_state_e state_q, state_d;
  logic [BUFFER_WIDTH-1:0]   hdr_q, hdr_d;
  logic                      cr_hdr_rel_q, cr_hdr_rel_d;
  logic [CR_W-1:0]           cr_data_rel_q, cr_data_rel_d;
  logic                      ptr_err_q, ptr_err_d;
  logic [HDR_FIELD_SIZE-1:0] hdr_count;
  logic                      buf_empty;
  logic                      hs;
  logic                      r_hdr_inc;
  logic [CR_W-1:0]           hdr_credits;

  assign hdr_count = i_w_hdr_ptr - i_r_hdr_ptr;
  assign buf_empty = (i_w_hdr_ptr == i_r_hdr_ptr);
  assign hs        = (state_q == ST_LOADED) && i_hdr_ready;

  tl_rx_vc_cr_calc u_cr_calc (
    .i_length   (hdr_q[DW0_LSB +: LENGTH_W]),
    .i_has_data (hdr_q[DW0_LSB + FMT_HAS_DATA_BIT]),
    .o_credits  (hdr_credits)
  );

  // fetch FSM: load on free register or on handshake with more queued
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    r_hdr_inc = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (!buf_empty) begin
          hdr_d     = i_r_tlp_hdr;
          r_hdr_inc = 1'b1;
          state_d   = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (hs) begin
          if (!buf_empty) begin
            hdr_d     = i_r_tlp_hdr;
            r_hdr_inc = 1'b1;
          end else begin
            state_d   = ST_EMPTY;
          end
        end
      end
    endcase
    if (i_rst)
      r_hdr_inc = 1'b0;
  end

  // credits of the header handed off this cycle; sticky pointer check
  always_comb begin
    cr_hdr_rel_d  = hs;
    cr_data_rel_d = '0;
    if (hs)
      cr_data_rel_d = hdr_credits;
    ptr_err_d     = ptr_err_q | (hdr_count > DEPTH);
  end

  // state and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_EMPTY;
      hdr_q         <= '0;
      cr_hdr_rel_q  <= 1'b0;
      cr_data_rel_q <= '0;
      ptr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      cr_hdr_rel_q  <= cr_hdr_rel_d;
      cr_data_rel_q <= cr_data_rel_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

  assign o_r_hdr_inc    = r_hdr_inc;
  assign o_hdr_valid    = (state_q == ST_LOADED);
  assign o_hdr          = hdr_q;
  assign o_hdr_has_data = hdr_q[DW0_LSB + FMT_HAS_DATA_BIT];
  assign o_hdr_length   = hdr_q[DW0_LSB +: LENGTH_W];
  assign o_cr_hdr_rel   = cr_hdr_rel_q;
  assign o_cr_data_rel  = cr_data_rel_q;
  assign o_hdr_count    = hdr_count;
  assign o_ptr_err      = ptr_err_q;

endmodule
